rle_param: RTL and testbench

RLE_PARAM -- requirements
Module: rle_param

---
 rtl/rle_pkg.sv | 18 +
 rtl/rle_byte_packer.sv | 58 +++++
 rtl/rle_param.sv | 170 +++++++++++++++++
 tb/tb_rle_param.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared definitions for the run-length encoder.
//   WORD_W     : memory word width
//   ADDR_W     : memory byte-address width
//   state_t    : controller state encoding
//   push_req_t : byte-lane write request into the output packer
package rle_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, SCAN, WR, FLUSH, FIN
  } state_t;

  typedef struct packed {
    logic [2:0]        n;     // bytes valid in data, 0..4, LSB first
    logic [WORD_W-1:0] data;
  } push_req_t;
endpackage

// File: rtl/rle_byte_packer.sv
// Byte-stream to word packer for the RLE output.
//   clk, nreset : clock, async active-low reset
//   clr         : drop all buffered bytes (start of frame)
//   push, req   : append req.n bytes (LSB first) to the stream
//   pop         : retire the lowest word (after it has been written)
//   word        : lowest 4 buffered bytes, unused bytes read as zero
//   full        : at least 4 bytes buffered
//   partial     : 1..3 bytes buffered
module rle_byte_packer
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic              clr,
  input  logic              push,
  input  push_req_t         req,
  input  logic              pop,
  output logic [WORD_W-1:0] word,
  output logic              full,
  output logic              partial
);
  // Eight byte slots: the controller drains once 4 are held, so at most
  // 3 bytes are left when a 4-byte run record arrives.
  logic [7:0][7:0] bq, bn;
  logic [3:0]      cnt_q, cnt_n;

  always_comb begin
    bn    = bq;
    cnt_n = cnt_q;
    if (clr) begin
      bn    = '0;
      cnt_n = '0;
    end else if (pop) begin
      // Shifting in zeros keeps every slot above the fill level zero,
      // which gives the zero padding of the final partial word.
      bn    = {32'h0, bq[7:4]};
      cnt_n = (cnt_q > 4'd4) ? cnt_q - 4'd4 : 4'd0;
    end else if (push) begin
      for (int i = 0; i < 4; i++)
        if (i < int'(req.n)) bn[3'(int'(cnt_q) + i)] = req.data[8*i +: 8];
      cnt_n = cnt_q + {1'b0, req.n};
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      bq    <= '0;
      cnt_q <= '0;
    end else begin
      bq    <= bn;
      cnt_q <= cnt_n;
    end
  end

  assign word    = bq[3:0];
  assign full    = cnt_q >= 4'd4;
  assign partial = (cnt_q != 4'd0) && !full;
endmodule

// File: rtl/rle_param.sv
// Run-length encoder over a single-port word memory.
// Reads message_size bytes from message_addr, groups them into SYM_W-bit
// little-endian symbols, and writes (count, symbol) records packed LSB
// first into words starting at rle_addr.
//   clk, nreset          : clock, async active-low reset
//   start                : level request, taken in IDLE or FIN
//   message_addr/size    : source frame (bytes)
//   rle_addr             : output area
//   rle_size, done, error: result byte count, completion, bad-size flag
//   port_A_*             : memory port, read data one clock after address
module rle_param
  import rle_pkg::*;
#(
  parameter int SYM_W = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  input  logic [31:0]       rle_addr,
  output logic [31:0]       rle_size,
  output logic              done,
  output logic              error,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [WORD_W-1:0] port_A_data_in,
  input  logic [WORD_W-1:0] port_A_data_out
);
  localparam int SB    = SYM_W / 8;
  localparam int CB    = CNT_W / 8;
  localparam int SPW   = 4 / SB;     // symbols per source word
  localparam int RUN_B = SB + CB;    // bytes per emitted run record
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_n;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [31:0]       bytes_left;
  logic [WORD_W-1:0] word_q;
  logic [2:0]        sym_idx;
  logic [SYM_W-1:0]  run_sym, cur_sym;
  logic [CNT_W-1:0]  run_cnt;
  logic              have_run;
  logic              accept, bad_size, scan_go, at_end, word_end;
  logic              do_sym, do_next, do_final, brk, push;
  logic              pk_full, pk_partial;
  logic [WORD_W-1:0] pk_word;
  push_req_t         pk_req;
  logic              unused;

  assign unused = ^{message_addr[31:ADDR_W], message_addr[1:0],
                    rle_addr[31:ADDR_W], rle_addr[1:0]};

  assign accept   = (state == IDLE || state == FIN) && start;
  assign bad_size = (message_size & 32'(SB - 1)) != 32'd0;
  assign scan_go  = (state == SCAN) && !pk_full;
  assign at_end   = bytes_left == 32'd0;
  assign word_end = sym_idx == 3'(SPW);
  assign do_final = scan_go && at_end && have_run;
  assign do_next  = scan_go && !at_end && word_end;
  assign do_sym   = scan_go && !at_end && !word_end;
  assign cur_sym  = SYM_W'(word_q >> (int'(sym_idx) * SYM_W));
  // A run closes on a new symbol or when its count is already saturated;
  // the closing symbol then starts the next run at count 1.
  assign brk      = (cur_sym != run_sym) || (run_cnt == CNT_MAX);
  assign push     = do_final || (do_sym && have_run && brk);

  assign pk_req.n    = 3'(RUN_B);
  assign pk_req.data = WORD_W'(run_cnt) | (WORD_W'(run_sym) << CNT_W);

  rle_byte_packer u_pack (
    .clk     (clk),
    .nreset  (nreset),
    .clr     (accept),
    .push    (push),
    .req     (pk_req),
    .pop     (state == WR),
    .word    (pk_word),
    .full    (pk_full),
    .partial (pk_partial)
  );

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_n;
  end

  // Next state
  always_comb begin
    state_n = state;
    case (state)
      IDLE, FIN: begin
        if (start) state_n = (message_size == 32'd0 || bad_size) ? FIN : RD_REQ;
        else       state_n = IDLE;
      end
      RD_REQ:  state_n = RD_WAIT;
      RD_WAIT: state_n = SCAN;
      SCAN: begin
        if (pk_full)       state_n = WR;
        else if (at_end)   state_n = have_run ? SCAN : FLUSH;
        else if (word_end) state_n = RD_REQ;
      end
      WR:      state_n = SCAN;
      FLUSH:   state_n = pk_partial ? WR : FIN;
      default: state_n = IDLE;
    endcase
  end

  // Memory port outputs; all zero outside their owning states
  always_comb begin
    port_A_we      = (state == WR);
    port_A_data_in = port_A_we ? pk_word : '0;
    case (state)
      RD_REQ, RD_WAIT: port_A_addr = rd_addr;
      WR:              port_A_addr = wr_addr;
      default:         port_A_addr = '0;
    endcase
  end
  assign port_A_clk = clk;

  // Datapath
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_addr    <= '0;
      wr_addr    <= '0;
      bytes_left <= '0;
      word_q     <= '0;
      sym_idx    <= '0;
      run_sym    <= '0;
      run_cnt    <= '0;
      have_run   <= 1'b0;
      rle_size   <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      if (accept) begin
        rd_addr    <= {message_addr[ADDR_W-1:2], 2'b00};
        wr_addr    <= {rle_addr[ADDR_W-1:2], 2'b00};
        bytes_left <= message_size;
        rle_size   <= '0;
        error      <= bad_size;
        have_run   <= 1'b0;
      end
      if (state == RD_WAIT) begin
        word_q  <= port_A_data_out;
        sym_idx <= '0;
      end
      if (do_next) rd_addr <= rd_addr + ADDR_W'(4);
      if (do_sym) begin
        sym_idx    <= sym_idx + 3'd1;
        bytes_left <= bytes_left - 32'(SB);
        have_run   <= 1'b1;
        if (!have_run || brk) begin
          run_sym <= cur_sym;
          run_cnt <= CNT_W'(1);
        end else begin
          run_cnt <= run_cnt + CNT_W'(1);
        end
      end
      if (do_final)    have_run <= 1'b0;
      if (push)        rle_size <= rle_size + 32'(RUN_B);
      if (state == WR) wr_addr  <= wr_addr + ADDR_W'(4);
      if (state_n == FIN) done <= 1'b1;
      else if (accept)    done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rle_param.sv
// Bench for rle_param: one 8-bit-symbol and one 16-bit-symbol instance
// share stimulus and source memory; each frame is checked against a
// queue-based reference model plus table constants.
module tb_rle_param;
  typedef logic [31:0] wq_t[$];
  typedef logic [47:0] wr_t;

  typedef struct {
    string       name;
    int          size;
    logic [31:0] fill;
    logic [31:0] last;
    int          sz8;
    logic [31:0] w8;
    int          sz16;
    logic [31:0] w16;
    bit          err16;
  } vec_t;

  logic        clk = 1'b0;
  logic        nreset, start;
  logic [31:0] message_addr, message_size, rle_addr;
  logic [31:0] sz8, sz16, din8, din16, dout8, dout16;
  logic        done8, done16, err8, err16, we8, we16, pclk8, pclk16;
  logic [15:0] addr8, addr16;

  logic [31:0] src_mem [0:1023];
  wr_t         wlog8[$], wlog16[$];
  int          n_chk = 0, n_fail = 0;
  int          last_b8, last_b16;
  vec_t        vecs[8];

  always #5 clk = ~clk;

  rle_param #(.SYM_W(8), .CNT_W(8)) u8 (
    .clk(clk), .nreset(nreset), .start(start), .message_addr(message_addr),
    .message_size(message_size), .rle_addr(rle_addr), .rle_size(sz8),
    .done(done8), .error(err8), .port_A_clk(pclk8), .port_A_addr(addr8),
    .port_A_we(we8), .port_A_data_in(din8), .port_A_data_out(dout8));

  rle_param #(.SYM_W(16), .CNT_W(8)) u16 (
    .clk(clk), .nreset(nreset), .start(start), .message_addr(message_addr),
    .message_size(message_size), .rle_addr(rle_addr), .rle_size(sz16),
    .done(done16), .error(err16), .port_A_clk(pclk16), .port_A_addr(addr16),
    .port_A_we(we16), .port_A_data_in(din16), .port_A_data_out(dout16));

  // Synchronous-read memory; writes are only logged, never stored.
  always @(posedge clk) begin
    dout8  <= src_mem[addr8[11:2]];
    dout16 <= src_mem[addr16[11:2]];
    if (we8)  wlog8.push_back({addr8, din8});
    if (we16) wlog16.push_back({addr16, din16});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".size8"}, sz8, 0);   chk({tag, ".size16"}, sz16, 0);
    chk({tag, ".done8"}, done8, 0); chk({tag, ".done16"}, done16, 0);
    chk({tag, ".err8"}, err8, 0);   chk({tag, ".err16"}, err16, 0);
    chk({tag, ".we8"}, we8, 0);     chk({tag, ".we16"}, we16, 0);
    chk({tag, ".addr8"}, addr8, 0); chk({tag, ".addr16"}, addr16, 0);
    chk({tag, ".din8"}, din8, 0);   chk({tag, ".din16"}, din16, 0);
    chk({tag, ".pclk8"}, pclk8, clk);
  endtask

  // Reference: bytes -> symbols -> runs (max 255) -> byte stream -> words.
  function automatic void model(input int n, input int sb, output wq_t wq, output int nb);
    logic [7:0]  st[$];
    logic [15:0] sym, cur;
    logic [31:0] w;
    int          cnt;
    cnt = 0; sym = '0; wq = {};
    for (int s = 0; s < n / sb; s++) begin
      cur = '0;
      for (int b = 0; b < sb; b++)
        cur |= 16'(src_mem[(s*sb+b)/4][8*((s*sb+b)%4) +: 8]) << (8*b);
      if (cnt > 0 && cur == sym && cnt < 255) cnt++;
      else begin
        if (cnt > 0) begin
          st.push_back(8'(cnt)); st.push_back(sym[7:0]);
          if (sb == 2) st.push_back(sym[15:8]);
        end
        sym = cur; cnt = 1;
      end
    end
    if (cnt > 0) begin
      st.push_back(8'(cnt)); st.push_back(sym[7:0]);
      if (sb == 2) st.push_back(sym[15:8]);
    end
    nb = st.size();
    for (int i = 0; i < nb; i += 4) begin
      w = '0;
      for (int j = 0; j < 4; j++) if (i + j < nb) w |= 32'(st[i+j]) << (8*j);
      wq.push_back(w);
    end
  endfunction

  task automatic load_fill(input int size, input logic [31:0] fill, input logic [31:0] last);
    int nw;
    nw = (size + 3) / 4;
    for (int i = 0; i < nw; i++) src_mem[i] = (i == nw - 1) ? last : fill;
  endtask

  task automatic load_rand(input int size);
    logic [7:0] cur;
    cur = 8'($urandom_range(0, 3));
    for (int i = 0; i < (size + 3) / 4; i++) src_mem[i] = $urandom;
    for (int i = 0; i < size; i++) begin
      if ($urandom_range(0, 3) == 0) cur = 8'($urandom_range(0, 3));
      src_mem[i/4][8*(i%4) +: 8] = cur;
    end
  endtask

  task automatic run_frame(input string nm, input int size, input logic [15:0] oaddr, input bit poke);
    wq_t e8, e16;
    int  es8, es16, b8, b16, c8, c16;
    bit  bad16;
    model(size, 1, e8, es8);
    model(size, 2, e16, es16);
    bad16 = (size % 2) != 0;
    if (bad16) begin es16 = 0; e16 = {}; end
    b8 = wlog8.size(); b16 = wlog16.size();
    last_b8 = b8; last_b16 = b16;
    @(negedge clk);
    nreset = 1'b1; start = 1'b1;
    message_addr = 32'h0; message_size = size; rle_addr = {16'h0, oaddr};
    @(negedge clk);
    start = 1'b0;
    if (size > 0) chk({nm, ".done8_clr"}, done8, 0);
    if (size > 0 && !bad16) chk({nm, ".done16_clr"}, done16, 0);
    chk({nm, ".err16_accept"}, err16, bad16);
    c8 = 0; c16 = 0;
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      if (done8 && c8 == 0) c8 = cyc;
      if (done16 && c16 == 0) c16 = cyc;
      if (c8 != 0 && c16 != 0) break;
      if (poke && cyc == 4) begin start = 1'b1; message_size = 32'd3; end
      if (poke && cyc == 6) begin start = 1'b0; message_size = size; end
      @(negedge clk);
    end
    chk({nm, ".timeout"}, (c8 != 0 && c16 != 0), 1);
    if (size == 0) chk({nm, ".zero_lat"}, (c8 <= 4 && c16 <= 4), 1);
    repeat (3) @(negedge clk);
    chk({nm, ".done8"}, done8, 1);   chk({nm, ".done16"}, done16, 1);
    chk({nm, ".size8"}, sz8, es8);   chk({nm, ".size16"}, sz16, es16);
    chk({nm, ".err8"}, err8, 0);     chk({nm, ".err16"}, err16, bad16);
    chk({nm, ".nwr8"}, wlog8.size() - b8, e8.size());
    chk({nm, ".nwr16"}, wlog16.size() - b16, e16.size());
    for (int k = 0; k < e8.size(); k++)
      if (b8 + k < wlog8.size())
        chk({nm, ".wr8"}, wlog8[b8+k], {16'(oaddr + 16'(4*k)), e8[k]});
    for (int k = 0; k < e16.size(); k++)
      if (b16 + k < wlog16.size())
        chk({nm, ".wr16"}, wlog16[b16+k], {16'(oaddr + 16'(4*k)), e16[k]});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    wr_t   w;
    int    sz;
    nreset = 1'b0; start = 1'b0;
    message_addr = '0; message_size = '0; rle_addr = '0;
    for (int i = 0; i < 1024; i++) src_mem[i] = '0;

    vecs[0] = '{"zeros48", 48,  32'h00000000, 32'h00000000, 2,  32'h00000030, 3, 32'h00000018, 0};
    vecs[1] = '{"aa300",   300, 32'hAAAAAAAA, 32'hAAAAAAAA, 4,  32'hAA2DAAFF, 3, 32'h00AAAA96, 0};
    vecs[2] = '{"rep1234", 8,   32'h12341234, 32'h12341234, 16, 32'h12013401, 3, 32'h00123404, 0};
    vecs[3] = '{"tail99",  51,  32'h11111111, 32'h99111111, 2,  32'h00001133, 0, 32'h0, 1};
    vecs[4] = '{"odd7",    7,   32'h55555555, 32'h55555555, 2,  32'h00005507, 0, 32'h0, 1};
    vecs[5] = '{"empty",   0,   32'h0,        32'h0,        0,  32'h0,        0, 32'h0, 0};
    vecs[6] = '{"sat255",  255, 32'h01010101, 32'h01010101, 2,  32'h000001FF, 0, 32'h0, 1};
    vecs[7] = '{"sat512",  512, 32'h01010101, 32'h01010101, 6,  32'h01FF01FF, 6, 32'h010101FF, 0};

    #12 chk_reset("reset");

    for (int v = 0; v < 8; v++) begin
      load_fill(vecs[v].size, vecs[v].fill, vecs[v].last);
      run_frame(vecs[v].name, vecs[v].size, 16'h0800, 1'b0);
      chk({vecs[v].name, ".tsize8"}, sz8, vecs[v].sz8);
      chk({vecs[v].name, ".tsize16"}, sz16, vecs[v].sz16);
      chk({vecs[v].name, ".terr16"}, err16, vecs[v].err16);
      if (vecs[v].sz8 > 0 && wlog8.size() > last_b8) begin
        w = wlog8[last_b8];
        chk({vecs[v].name, ".tword8"}, w[31:0], vecs[v].w8);
      end
      if (vecs[v].sz16 > 0 && wlog16.size() > last_b16) begin
        w = wlog16[last_b16];
        chk({vecs[v].name, ".tword16"}, w[31:0], vecs[v].w16);
      end
    end

    // start pulses while busy must not disturb the frame in flight
    load_rand(200);
    run_frame("busy_start", 200, 16'h0900, 1'b1);

    // reset in the middle of a frame, then a fresh frame straight after release
    load_fill(300, 32'hAAAAAAAA, 32'hAAAAAAAA);
    @(negedge clk);
    start = 1'b1; message_size = 32'd300; rle_addr = 32'h0800;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    #2 nreset = 1'b0;
    #1 chk_reset("midrst");
    load_rand(90);
    run_frame("after_rst", 90, 16'h0A00, 1'b0);

    for (int r = 0; r < 12; r++) begin
      sz = (r % 4 == 3) ? int'($urandom_range(0, 500)) : int'($urandom_range(0, 160));
      load_rand(sz);
      run_frame("rand", sz, 16'h0800, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
